// File: rtl/adsd_risc_pkg.sv
// Shared definitions for the ADSD RISC multi-cycle controller.
//   - opcode encodings (IR[15:12])
//   - ALU operation codes driven on ctrl_aluop
//   - controller state encoding (visible on state_o)
//   - decoded-instruction record produced by adsd_risc_op_decode
package adsd_risc_pkg;

  // Instruction opcodes
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0110;
  localparam logic [3:0] OP_ROL  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1000;
  localparam logic [3:0] OP_BEQ  = 4'b1001;
  localparam logic [3:0] OP_BLT  = 4'b1010;
  localparam logic [3:0] OP_BGT  = 4'b1011;
  localparam logic [3:0] OP_LD   = 4'b1100;
  localparam logic [3:0] OP_ST   = 4'b1101;
  localparam logic [3:0] OP_JMP  = 4'b1110;
  localparam logic [3:0] OP_ADDI = 4'b1111;

  // ALU operations that are not simply the opcode passed through
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_NOT = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  // CLS_ALU: register ALU ops and NOT (write-back uses default selects)
  // CLS_IMM: shifts and addi (EXEC selects held through write-back)
  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_IMM,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_LOAD,
    CLS_STORE
  } op_class_e;

  typedef struct packed {
    op_class_e  cls;
    logic [3:0] aluop;
    logic       alu_in2_sel;
    logic       rf_rd_sel;
    logic       wdata_sel;
    logic       d_mem_rw_;
  } op_dec_t;

endpackage

// File: rtl/adsd_risc_op_decode.sv
// Combinational opcode decoder for the multi-cycle controller.
// The returned fields are the EXEC-cycle datapath selects for the latched
// opcode; the FSM decides in which states they are actually driven.
//   op  : latched opcode (op_q)
//   dec : instruction class plus aluop/alu_in2_sel/rf_rd_sel/wdata_sel/d_mem_rw_
module adsd_risc_op_decode
  import adsd_risc_pkg::*;
(
  input  logic [3:0] op,
  output op_dec_t    dec
);

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // field unassigned, which would otherwise infer a latch.
    dec.cls         = CLS_ALU;
    dec.aluop       = ALU_ADD;
    dec.alu_in2_sel = 1'b0;
    dec.rf_rd_sel   = 1'b1;
    dec.wdata_sel   = 1'b1;
    dec.d_mem_rw_   = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        dec.aluop = op;
      end
      OP_SLL, OP_SRL, OP_SRA, OP_ROL: begin
        dec.cls         = CLS_IMM;
        dec.aluop       = op;
        dec.alu_in2_sel = 1'b1;
        dec.rf_rd_sel   = 1'b0;
      end
      OP_NOT: begin
        dec.aluop     = ALU_NOT;
        dec.rf_rd_sel = 1'b0;
      end
      OP_ADDI: begin
        dec.cls         = CLS_IMM;
        dec.alu_in2_sel = 1'b1;
        dec.rf_rd_sel   = 1'b0;
      end
      OP_BEQ, OP_BLT, OP_BGT: begin
        dec.cls   = CLS_BRANCH;
        dec.aluop = ALU_SUB;
      end
      OP_JMP: begin
        dec.cls = CLS_JUMP;
      end
      OP_LD: begin
        dec.cls         = CLS_LOAD;
        dec.alu_in2_sel = 1'b1;
        dec.wdata_sel   = 1'b0;
        dec.d_mem_rw_   = 1'b1;
      end
      OP_ST: begin
        dec.cls         = CLS_STORE;
        dec.alu_in2_sel = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/adsd_risc_mc_ctrl.sv
// Multi-cycle control FSM for the 16-bit ADSD RISC datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB with ready handshakes on instruction
// and data memory, gates execution on run at instruction boundaries, and
// traps to a sticky FAULT state when a memory stays not-ready for more than
// WAIT_MAX consecutive cycles.
//   clk, rst            : clock, synchronous active-low reset
//   run                 : execute enable, sampled only when an instruction retires / in IDLE
//   opcode              : IR[15:12], valid from DECODE onward
//   zero, neg           : ALU flags for branch resolution
//   i_mem_ready         : instruction memory data valid
//   d_mem_ready         : data memory access completes
//   pc_ld .. ctrl_aluop : datapath strobes (same set as the single-cycle controller plus ir_ld)
//   instr_done          : one-cycle retire pulse (equal to pc_ld)
//   fault               : sticky memory-timeout flag
//   state_o             : current state code
module adsd_risc_mc_ctrl
  import adsd_risc_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       neg,
  input  logic       i_mem_ready,
  input  logic       d_mem_ready,
  output logic       pc_ld,
  output logic       ir_ld,
  output logic       ctrl_branch,
  output logic       ctrl_jump,
  output logic       ctrl_i_mem_oe,
  output logic       ctrl_rf_rd_sel,
  output logic       ctrl_rf_write_en,
  output logic       ctrl_alu_in2_sel,
  output logic       ctrl_d_mem_rw_,
  output logic       ctrl_d_mem_cs,
  output logic       ctrl_wdata_sel,
  output logic [3:0] ctrl_aluop,
  output logic       instr_done,
  output logic       fault,
  output logic [2:0] state_o
);

  localparam int unsigned      CNT_W   = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

  state_e           state_q, state_d, retire_state;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             fault_q;
  logic             waiting;
  op_dec_t          dec;

  adsd_risc_op_decode u_op_decode (
    .op  (op_q),
    .dec (dec)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_q | (state_d == S_FAULT);
      if (state_q == S_DECODE) begin
        op_q <= opcode;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    retire_state     = run ? S_FETCH : S_IDLE;
    waiting          = 1'b0;
    wait_cnt_d       = wait_cnt_q;
    pc_ld            = 1'b0;
    ir_ld            = 1'b0;
    ctrl_branch      = 1'b0;
    ctrl_jump        = 1'b0;
    ctrl_i_mem_oe    = 1'b0;
    ctrl_rf_rd_sel   = 1'b1;
    ctrl_rf_write_en = 1'b0;
    ctrl_alu_in2_sel = 1'b0;
    ctrl_d_mem_rw_   = 1'b0;
    ctrl_d_mem_cs    = 1'b0;
    ctrl_wdata_sel   = 1'b1;
    ctrl_aluop       = ALU_ADD;

    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        ctrl_i_mem_oe = 1'b1;
        if (i_mem_ready) begin
          ir_ld   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_cnt_q == CNT_MAX) begin
          state_d = S_FAULT;
        end else begin
          waiting = 1'b1;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        ctrl_aluop       = dec.aluop;
        ctrl_alu_in2_sel = dec.alu_in2_sel;
        ctrl_rf_rd_sel   = dec.rf_rd_sel;
        unique case (dec.cls)
          CLS_BRANCH: begin
            // Flags come straight from the ALU compare in this same cycle.
            case (op_q)
              OP_BEQ:  ctrl_branch = zero;
              OP_BLT:  ctrl_branch = neg;
              default: ctrl_branch = !zero && !neg;
            endcase
            pc_ld   = 1'b1;
            state_d = retire_state;
          end
          CLS_JUMP: begin
            ctrl_jump = 1'b1;
            pc_ld     = 1'b1;
            state_d   = retire_state;
          end
          CLS_LOAD, CLS_STORE: state_d = S_MEM;
          default:             state_d = S_WB;
        endcase
      end
      S_MEM: begin
        ctrl_d_mem_cs    = 1'b1;
        ctrl_alu_in2_sel = dec.alu_in2_sel;
        ctrl_aluop       = dec.aluop;
        ctrl_d_mem_rw_   = dec.d_mem_rw_;
        if (d_mem_ready) begin
          if (dec.cls == CLS_STORE) begin
            pc_ld   = 1'b1;
            state_d = retire_state;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_cnt_q == CNT_MAX) begin
          state_d = S_FAULT;
        end else begin
          waiting = 1'b1;
        end
      end
      S_WB: begin
        ctrl_rf_write_en = 1'b1;
        pc_ld            = 1'b1;
        // Immediate/shift results and load data still flow through the
        // EXEC-time selects while the register file captures them.
        if (dec.cls == CLS_IMM || dec.cls == CLS_LOAD) begin
          ctrl_aluop       = dec.aluop;
          ctrl_alu_in2_sel = dec.alu_in2_sel;
          ctrl_rf_rd_sel   = (dec.cls == CLS_LOAD) ? 1'b0 : dec.rf_rd_sel;
          ctrl_wdata_sel   = dec.wdata_sel;
        end
        state_d = retire_state;
      end
      S_FAULT: ;
      default: state_d = S_IDLE;
    endcase

    // The watchdog only measures consecutive stalls within one state.
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (waiting) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  assign instr_done = pc_ld;
  assign fault      = fault_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_adsd_risc_mc_ctrl.sv
// Scoreboard bench for adsd_risc_mc_ctrl: each scenario task drives inputs
// cycle by cycle and queues the output vector expected for that cycle; a
// negedge monitor pops and compares against the DUT.
module tb_adsd_risc_mc_ctrl;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_DEC   = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_MEM   = 3'd4;
  localparam logic [2:0] ST_WB    = 3'd5;
  localparam logic [2:0] ST_FAULT = 3'd6;

  logic       clk, rst, run, zero, neg, i_mem_ready, d_mem_ready;
  logic [3:0] opcode;
  logic       pc_ld, ir_ld, ctrl_branch, ctrl_jump, ctrl_i_mem_oe, ctrl_rf_rd_sel;
  logic       ctrl_rf_write_en, ctrl_alu_in2_sel, ctrl_d_mem_rw_, ctrl_d_mem_cs, ctrl_wdata_sel;
  logic [3:0] ctrl_aluop;
  logic       instr_done, fault;
  logic [2:0] state_o;

  typedef struct packed {
    logic [2:0] st;
    logic       flt;
    logic       pc;
    logic       ir;
    logic       br;
    logic       jmp;
    logic       oe;
    logic       rd;
    logic       we;
    logic       in2;
    logic       rw;
    logic       cs;
    logic       wd;
    logic       done;
    logic [3:0] alu;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  v;
  } sb_t;

  sb_t  sb_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   retired = 0;
  obs_t act;

  adsd_risc_mc_ctrl #(.WAIT_MAX(15)) dut (
    .clk              (clk),
    .rst              (rst),
    .run              (run),
    .opcode           (opcode),
    .zero             (zero),
    .neg              (neg),
    .i_mem_ready      (i_mem_ready),
    .d_mem_ready      (d_mem_ready),
    .pc_ld            (pc_ld),
    .ir_ld            (ir_ld),
    .ctrl_branch      (ctrl_branch),
    .ctrl_jump        (ctrl_jump),
    .ctrl_i_mem_oe    (ctrl_i_mem_oe),
    .ctrl_rf_rd_sel   (ctrl_rf_rd_sel),
    .ctrl_rf_write_en (ctrl_rf_write_en),
    .ctrl_alu_in2_sel (ctrl_alu_in2_sel),
    .ctrl_d_mem_rw_   (ctrl_d_mem_rw_),
    .ctrl_d_mem_cs    (ctrl_d_mem_cs),
    .ctrl_wdata_sel   (ctrl_wdata_sel),
    .ctrl_aluop       (ctrl_aluop),
    .instr_done       (instr_done),
    .fault            (fault),
    .state_o          (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    act.st   = state_o;
    act.flt  = fault;
    act.pc   = pc_ld;
    act.ir   = ir_ld;
    act.br   = ctrl_branch;
    act.jmp  = ctrl_jump;
    act.oe   = ctrl_i_mem_oe;
    act.rd   = ctrl_rf_rd_sel;
    act.we   = ctrl_rf_write_en;
    act.in2  = ctrl_alu_in2_sel;
    act.rw   = ctrl_d_mem_rw_;
    act.cs   = ctrl_d_mem_cs;
    act.wd   = ctrl_wdata_sel;
    act.done = instr_done;
    act.alu  = ctrl_aluop;
  end

  // Scoreboard consumer: one expected vector per clock, checked mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      sb_t s;
      s = sb_q.pop_front();
      checks++;
      if (act !== s.v) begin
        errors++;
        $display("FAIL %s: observed %h expected %h (st/flt/pc/ir/br/jmp/oe/rd/we/in2/rw/cs/wd/done/alu)",
                 s.tag, act, s.v);
      end
    end
  end

  always @(negedge clk) begin
    if (instr_done === 1'b1) retired++;
  end

  function automatic obs_t b(input logic [2:0] st);
    obs_t e;
    e    = '0;
    e.st = st;
    e.rd = 1'b1;
    e.wd = 1'b1;
    return e;
  endfunction

  // Queue the expectation for the current cycle, then advance one clock.
  task automatic cyc(input obs_t e, input string tag);
    sb_t s;
    s.tag = tag;
    s.v   = e;
    sb_q.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic do_fd(input logic [3:0] op, input string tag);
    obs_t e;
    opcode      = op;
    i_mem_ready = 1'b1;
    e = b(ST_FETCH); e.oe = 1'b1; e.ir = 1'b1;
    cyc(e, {tag, "_fetch"});
    cyc(b(ST_DEC), {tag, "_decode"});
  endtask

  task automatic do_alu(input logic [3:0] op, input logic in2, input logic rd,
                        input logic [3:0] alu, input logic hold, input string tag);
    obs_t e;
    do_fd(op, tag);
    e = b(ST_EXEC); e.in2 = in2; e.rd = rd; e.alu = alu;
    cyc(e, {tag, "_exec"});
    e = b(ST_WB); e.we = 1'b1; e.pc = 1'b1; e.done = 1'b1;
    if (hold) begin
      e.in2 = in2; e.rd = rd; e.alu = alu;
    end
    cyc(e, {tag, "_wb"});
  endtask

  task automatic do_br(input logic [3:0] op, input logic z, input logic n,
                       input logic taken, input string tag);
    obs_t e;
    do_fd(op, tag);
    zero = z;
    neg  = n;
    e = b(ST_EXEC); e.alu = 4'b0001; e.pc = 1'b1; e.done = 1'b1; e.br = taken;
    cyc(e, {tag, "_exec"});
  endtask

  task automatic test_reset();
    rst = 1'b0; run = 1'b0; opcode = 4'b0000; zero = 1'b0; neg = 1'b0;
    i_mem_ready = 1'b0; d_mem_ready = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (act !== b(ST_IDLE)) begin
      errors++;
      $display("FAIL reset_outputs: observed %h expected %h", act, b(ST_IDLE));
    end
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_fault: observed %b expected 0", fault);
    end
    cyc(b(ST_IDLE), "reset_hold");
    rst = 1'b1;
    repeat (2) cyc(b(ST_IDLE), "idle_run0");
  endtask

  task automatic test_alu();
    int r0;
    run = 1'b1;
    cyc(b(ST_IDLE), "idle_to_fetch");
    r0 = retired;
    do_alu(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, "add");
    checks++;
    if (state_o !== ST_FETCH || retired != r0 + 1) begin
      errors++;
      $display("FAIL add_retire: state %0d retired %0d, need state 1 retired %0d",
               state_o, retired - r0, 1);
    end
    do_alu(4'b0001, 1'b0, 1'b1, 4'b0001, 1'b0, "sub");
    do_alu(4'b0011, 1'b0, 1'b1, 4'b0011, 1'b0, "or");
    do_alu(4'b1000, 1'b0, 1'b0, 4'b1000, 1'b0, "not");
    do_alu(4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, "sll");
    do_alu(4'b0111, 1'b1, 1'b0, 4'b0111, 1'b1, "rol");
    do_alu(4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, "addi");
  endtask

  task automatic test_branch();
    obs_t e;
    int   r0;
    r0 = retired;
    do_br(4'b1001, 1'b1, 1'b0, 1'b1, "beq_taken");
    do_br(4'b1001, 1'b0, 1'b0, 1'b0, "beq_not");
    do_br(4'b1010, 1'b0, 1'b1, 1'b1, "blt_taken");
    do_br(4'b1010, 1'b1, 1'b0, 1'b0, "blt_not");
    do_br(4'b1011, 1'b0, 1'b0, 1'b1, "bgt_taken");
    do_br(4'b1011, 1'b1, 1'b0, 1'b0, "bgt_zero");
    do_br(4'b1011, 1'b0, 1'b1, 1'b0, "bgt_neg");
    do_fd(4'b1110, "jmp");
    e = b(ST_EXEC); e.jmp = 1'b1; e.pc = 1'b1; e.done = 1'b1;
    cyc(e, "jmp_exec");
    checks++;
    if (state_o !== ST_FETCH || retired != r0 + 8) begin
      errors++;
      $display("FAIL branch_retire: state %0d retired %0d, need state 1 retired 8",
               state_o, retired - r0);
    end
    zero = 1'b0;
    neg  = 1'b0;
  endtask

  task automatic test_load_wait();
    obs_t e;
    int   r0;
    r0 = retired;
    do_fd(4'b1100, "ld");
    d_mem_ready = 1'b0;
    e = b(ST_EXEC); e.in2 = 1'b1;
    cyc(e, "ld_exec");
    for (int i = 0; i < 3; i++) begin
      d_mem_ready = (i == 2);
      e = b(ST_MEM); e.cs = 1'b1; e.rw = 1'b1; e.in2 = 1'b1;
      cyc(e, "ld_mem");
    end
    e = b(ST_WB); e.we = 1'b1; e.pc = 1'b1; e.done = 1'b1;
    e.in2 = 1'b1; e.rd = 1'b0; e.wd = 1'b0;
    cyc(e, "ld_wb");
    checks++;
    if (retired != r0 + 1) begin
      errors++;
      $display("FAIL ld_retire_count: observed %0d expected 1", retired - r0);
    end
  endtask

  task automatic test_store();
    obs_t e;
    int   r0;
    r0 = retired;
    do_fd(4'b1101, "st");
    d_mem_ready = 1'b1;
    e = b(ST_EXEC); e.in2 = 1'b1;
    cyc(e, "st_exec");
    e = b(ST_MEM); e.cs = 1'b1; e.in2 = 1'b1; e.pc = 1'b1; e.done = 1'b1;
    cyc(e, "st_mem");
    checks++;
    if (state_o !== ST_FETCH || retired != r0 + 1) begin
      errors++;
      $display("FAIL st_retire: state %0d retired %0d, need state 1 retired 1",
               state_o, retired - r0);
    end
  endtask

  task automatic test_fetch_watchdog();
    obs_t e;
    // Ready arrives on the last tolerated cycle: no fault.
    opcode      = 4'b0000;
    i_mem_ready = 1'b0;
    e = b(ST_FETCH); e.oe = 1'b1;
    repeat (15) cyc(e, "fw_wait");
    i_mem_ready = 1'b1;
    e.ir = 1'b1;
    cyc(e, "fw_fetch_at_limit");
    cyc(b(ST_DEC), "fw_decode");
    cyc(b(ST_EXEC), "fw_exec");
    e = b(ST_WB); e.we = 1'b1; e.pc = 1'b1; e.done = 1'b1;
    cyc(e, "fw_wb");
    // One stall too many: FAULT.
    i_mem_ready = 1'b0;
    e = b(ST_FETCH); e.oe = 1'b1;
    repeat (16) cyc(e, "to_wait");
    i_mem_ready = 1'b1;
    d_mem_ready = 1'b1;
    e = b(ST_FAULT); e.flt = 1'b1;
    repeat (3) cyc(e, "fault_hold");
    checks++;
    if (fault !== 1'b1 || state_o !== ST_FAULT) begin
      errors++;
      $display("FAIL fault_sticky: fault %b state %0d, need fault 1 state 6", fault, state_o);
    end
    rst = 1'b0;
    cyc(e, "fault_at_rst");
    rst = 1'b1;
    run = 1'b0;
    cyc(b(ST_IDLE), "after_fault_rst");
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear: observed %b expected 0", fault);
    end
  endtask

  task automatic test_run_drop();
    obs_t e;
    int   r0;
    run = 1'b1;
    cyc(b(ST_IDLE), "rd_idle");
    r0          = retired;
    opcode      = 4'b1111;
    i_mem_ready = 1'b1;
    e = b(ST_FETCH); e.oe = 1'b1; e.ir = 1'b1;
    cyc(e, "rd_fetch");
    run = 1'b0;
    cyc(b(ST_DEC), "rd_decode");
    e = b(ST_EXEC); e.in2 = 1'b1; e.rd = 1'b0;
    cyc(e, "rd_exec");
    e = b(ST_WB); e.in2 = 1'b1; e.rd = 1'b0; e.we = 1'b1; e.pc = 1'b1; e.done = 1'b1;
    cyc(e, "rd_wb");
    repeat (2) cyc(b(ST_IDLE), "rd_idle_after");
    checks++;
    if (state_o !== ST_IDLE || retired != r0 + 1) begin
      errors++;
      $display("FAIL run_drop_idle: state %0d retired %0d, need state 0 retired 1",
               state_o, retired - r0);
    end
  endtask

  task automatic test_reset_mid_mem();
    obs_t e;
    int   r0;
    run = 1'b1;
    cyc(b(ST_IDLE), "rm_idle");
    r0 = retired;
    do_fd(4'b1100, "rm_ld");
    d_mem_ready = 1'b0;
    e = b(ST_EXEC); e.in2 = 1'b1;
    cyc(e, "rm_exec");
    e = b(ST_MEM); e.cs = 1'b1; e.rw = 1'b1; e.in2 = 1'b1;
    cyc(e, "rm_mem");
    rst = 1'b0;
    cyc(e, "rm_mem_rst");
    rst = 1'b1;
    run = 1'b0;
    cyc(b(ST_IDLE), "rm_after_rst");
    checks++;
    if (ctrl_rf_write_en !== 1'b0 || ctrl_d_mem_cs !== 1'b0 || retired != r0) begin
      errors++;
      $display("FAIL rm_no_write: we %b cs %b retired %0d, need 0 0 0",
               ctrl_rf_write_en, ctrl_d_mem_cs, retired - r0);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_load_wait();
    test_store();
    test_fetch_watchdog();
    test_run_drop();
    test_reset_mid_mem();
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: observed %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
